// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared widths and result entry type for the multiply result path
package mul_pkg;
    localparam int DATA_W = 32;
    localparam int HALF_W = DATA_W / 2;
    localparam int REG_W  = 5;
    localparam int FIFO_D = 2;

    typedef struct packed {
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] result;
    } mul_entry_t;
endpackage

// File: rtl/mul_result_fifo.sv
// rtl/mul_result_fifo.sv - 2-entry show-ahead buffer between the adder stage and writeback
module mul_result_fifo
    import mul_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  mul_entry_t in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output mul_entry_t out_data,
    output logic [1:0] count
);
    mul_entry_t mem [FIFO_D];
    logic       wr_ptr;
    logic       rd_ptr;
    logic       do_wr;
    logic       do_rd;

    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign do_rd     = out_valid & out_ready;
    // A full buffer still accepts when the head drains in the same cycle.
    assign in_ready  = (count < 2'(FIFO_D)) | do_rd;
    assign do_wr     = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < FIFO_D; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_rd) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mul_result_combiner.sv
// rtl/mul_result_combiner.sv - combines multiplier partials into the low product word for writeback
module mul_result_combiner
    import mul_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              E_mul_issue,
    input  logic [REG_W-1:0]  E_dst_regnum,
    input  logic              M_en,
    input  logic [DATA_W-1:0] M_mul_cell_p1,
    input  logic [DATA_W-1:0] M_mul_cell_p2,
    input  logic [DATA_W-1:0] M_mul_cell_p3,
    input  logic              W_ready,
    output logic              W_mul_valid,
    output logic [DATA_W-1:0] W_mul_result,
    output logic [REG_W-1:0]  W_mul_dst_regnum,
    output logic              mul_stall,
    output logic              mul_busy,
    output logic              mul_drop_err
);
    logic              m_valid;
    logic [REG_W-1:0]  m_dst;
    logic              a_valid;
    logic [DATA_W-1:0] a_lo;
    logic [HALF_W-1:0] a_mid;
    logic [REG_W-1:0]  a_dst;
    logic              a_accept;
    logic              f_accept;
    logic [1:0]        f_count;
    mul_entry_t        f_in;
    mul_entry_t        f_out;

    // Upper partial halves only affect product bits above DATA_W.
    logic unused_hi;
    assign unused_hi = ^{M_mul_cell_p2[DATA_W-1:HALF_W], M_mul_cell_p3[DATA_W-1:HALF_W]};

    assign a_accept  = !a_valid | f_accept;
    assign mul_stall = m_valid & !a_accept;
    assign mul_busy  = m_valid | a_valid | (f_count != 2'd0);

    assign f_in.dst    = a_dst;
    assign f_in.result = a_lo + {a_mid, {HALF_W{1'b0}}};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            m_valid      <= 1'b0;
            m_dst        <= '0;
            a_valid      <= 1'b0;
            a_lo         <= '0;
            a_mid        <= '0;
            a_dst        <= '0;
            mul_drop_err <= 1'b0;
        end else begin
            // Stage M tracks the cell's register: reload on M_en, else drain into A.
            if (M_en) begin
                m_valid <= E_mul_issue;
                m_dst   <= E_dst_regnum;
            end else if (m_valid & a_accept) begin
                m_valid <= 1'b0;
            end
            if (M_en & mul_stall) begin
                mul_drop_err <= 1'b1;
            end
            if (m_valid & a_accept) begin
                a_valid <= 1'b1;
                a_lo    <= M_mul_cell_p1;
                a_mid   <= M_mul_cell_p2[HALF_W-1:0] + M_mul_cell_p3[HALF_W-1:0];
                a_dst   <= m_dst;
            end else if (f_accept) begin
                a_valid <= 1'b0;
            end
        end
    end

    mul_result_fifo u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (a_valid),
        .in_ready  (f_accept),
        .in_data   (f_in),
        .out_valid (W_mul_valid),
        .out_ready (W_ready),
        .out_data  (f_out),
        .count     (f_count)
    );

    assign W_mul_result     = f_out.result;
    assign W_mul_dst_regnum = f_out.dst;
endmodule
